// File: rtl/trans_mem_drain.sv
// Read-side drain engine: walks port B of the two transmit result memories and
// presents each stored byte as a valid/ready stream tagged with its source memory.
module trans_mem_drain #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   mem1_count,
  input  logic [ADDR_W:0]   mem2_count,
  output logic [ADDR_W-1:0] m1_addrb,
  output logic              m1_renb,
  input  logic [DATA_W-1:0] m1_doutb,
  output logic [ADDR_W-1:0] m2_addrb,
  output logic              m2_renb,
  input  logic [DATA_W-1:0] m2_doutb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(2 ** ADDR_W);
  localparam logic [1:0]       WAIT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic                src_q, src_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   m1_addrb_q, m1_addrb_d, m2_addrb_q, m2_addrb_d;
  logic                m1_renb_q, m1_renb_d, m2_renb_q, m2_renb_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_src_q, out_src_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [CNT_W-1:0]    c1_clamp, c2_clamp, idx_next, cur_cnt;
  logic                more, is_last;
  logic                issue_en, issue_src;
  logic [ADDR_W-1:0]   issue_idx;

  assign m1_addrb  = m1_addrb_q;
  assign m1_renb   = m1_renb_q;
  assign m2_addrb  = m2_addrb_q;
  assign m2_renb   = m2_renb_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;
    src_d       = src_q;
    idx_d       = idx_q;
    wait_cnt_d  = wait_cnt_q;
    m1_addrb_d  = m1_addrb_q;
    m2_addrb_d  = m2_addrb_q;
    m1_renb_d   = 1'b0;
    m2_renb_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue_en    = 1'b0;
    issue_src   = src_q;
    issue_idx   = '0;

    c1_clamp = (mem1_count > MAX_CNT) ? MAX_CNT : mem1_count;
    c2_clamp = (mem2_count > MAX_CNT) ? MAX_CNT : mem2_count;
    idx_next = {1'b0, idx_q} + CNT_W'(1);
    cur_cnt  = src_q ? cnt2_q : cnt1_q;
    more     = idx_next < cur_cnt;
    // The final byte is the last of memory 2, or the last of memory 1 when memory 2 is empty.
    is_last  = !more && (src_q || (cnt2_q == '0));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt1_d = c1_clamp;
          cnt2_d = c2_clamp;
          if (c1_clamp != '0) begin
            issue_en  = 1'b1;
            issue_src = 1'b0;
          end else if (c2_clamp != '0) begin
            issue_en  = 1'b1;
            issue_src = 1'b1;
          end else begin
            src_d   = 1'b0;
            idx_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          out_data_d  = src_q ? m2_doutb : m1_doutb;
          out_src_d   = src_q;
          out_last_d  = is_last;
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (more) begin
            issue_en  = 1'b1;
            issue_idx = idx_next[ADDR_W-1:0];
          end else if (!src_q && (cnt2_q != '0)) begin
            issue_en  = 1'b1;
            issue_src = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Launch a one-cycle port-B read; the unselected address keeps its last value.
    if (issue_en) begin
      state_d = S_ISSUE;
      busy_d  = 1'b1;
      src_d   = issue_src;
      idx_d   = issue_idx;
      if (issue_src) begin
        m2_renb_d  = 1'b1;
        m2_addrb_d = issue_idx;
      end else begin
        m1_renb_d  = 1'b1;
        m1_addrb_d = issue_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      src_q       <= 1'b0;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      m1_addrb_q  <= '0;
      m2_addrb_q  <= '0;
      m1_renb_q   <= 1'b0;
      m2_renb_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      src_q       <= src_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
      m1_addrb_q  <= m1_addrb_d;
      m2_addrb_q  <= m2_addrb_d;
      m1_renb_q   <= m1_renb_d;
      m2_renb_q   <= m2_renb_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_trans_mem_drain.sv
// Directed bench for trans_mem_drain: two port-B memory models with one-cycle read
// latency feed the DUT; each step compares against hand-computed streams.
module tb_trans_mem_drain;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] mem1_count = '0;
  logic [4:0] mem2_count = '0;
  logic [3:0] m1_addrb, m2_addrb;
  logic       m1_renb, m2_renb;
  logic [7:0] m1_doutb, m2_doutb;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_src, out_last, busy, done;

  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] got_data[$], exp_data[$];
  logic       got_src[$],  exp_src[$];
  logic       got_last[$], exp_last[$];
  logic [3:0] got_a1[$],   exp_a1[$];
  logic [3:0] got_a2[$],   exp_a2[$];
  int         first_valid, done_at;

  trans_mem_drain #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset), .start(start),
    .mem1_count(mem1_count), .mem2_count(mem2_count),
    .m1_addrb(m1_addrb), .m1_renb(m1_renb), .m1_doutb(m1_doutb),
    .m2_addrb(m2_addrb), .m2_renb(m2_renb), .m2_doutb(m2_doutb),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (m1_renb) m1_doutb <= mem1[m1_addrb];
    if (m2_renb) m2_doutb <= mem2[m2_addrb];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({out_valid, out_last, out_src, busy, done, m1_renb, m2_renb,
                m1_addrb, m2_addrb, out_data});
  endfunction

  task automatic exp_clear();
    exp_data.delete(); exp_src.delete(); exp_last.delete();
    exp_a1.delete(); exp_a2.delete();
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic s, input logic l);
    exp_data.push_back(d); exp_src.push_back(s); exp_last.push_back(l);
  endtask

  task automatic set_exp_basic();
    exp_clear();
    exp_byte(8'h11, 1'b0, 1'b0); exp_byte(8'h12, 1'b0, 1'b0); exp_byte(8'h13, 1'b0, 1'b0);
    exp_byte(8'hA1, 1'b1, 1'b0); exp_byte(8'hA2, 1'b1, 1'b1);
    exp_a1.push_back(4'd0); exp_a1.push_back(4'd1); exp_a1.push_back(4'd2);
    exp_a2.push_back(4'd0); exp_a2.push_back(4'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sample index i counts edges after the start edge; stops at the done pulse or budget.
  task automatic run_drain(input int budget, input int repulse);
    got_data.delete(); got_src.delete(); got_last.delete();
    got_a1.delete(); got_a2.delete();
    first_valid = -1;
    done_at     = -1;
    for (int i = 0; i < budget; i++) begin
      start = (i == repulse);
      if (out_valid && out_ready) begin
        got_data.push_back(out_data); got_src.push_back(out_src); got_last.push_back(out_last);
        if (first_valid < 0) first_valid = i;
      end
      if (m1_renb) got_a1.push_back(m1_addrb);
      if (m2_renb) got_a2.push_back(m2_addrb);
      if (done) begin
        done_at = i;
        break;
      end
      tick();
    end
    start = 1'b0;
    check("done_within_budget", 32'(done_at >= 0), 32'd1);
    tick();
    check("done_single_pulse", 32'({done, busy}), 32'd0);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_nbytes"}, 32'(got_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      check({tag, $sformatf("_data%0d", i)}, 32'(got_data[i]), 32'(exp_data[i]));
      check({tag, $sformatf("_src%0d", i)},  32'(got_src[i]),  32'(exp_src[i]));
      check({tag, $sformatf("_last%0d", i)}, 32'(got_last[i]), 32'(exp_last[i]));
    end
    check({tag, "_n_m1_reads"}, 32'(got_a1.size()), 32'(exp_a1.size()));
    for (int i = 0; i < got_a1.size() && i < exp_a1.size(); i++)
      check({tag, $sformatf("_m1addr%0d", i)}, 32'(got_a1[i]), 32'(exp_a1[i]));
    check({tag, "_n_m2_reads"}, 32'(got_a2.size()), 32'(exp_a2.size()));
    for (int i = 0; i < got_a2.size() && i < exp_a2.size(); i++)
      check({tag, $sformatf("_m2addr%0d", i)}, 32'(got_a2[i]), 32'(exp_a2[i]));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 8'h00;
      mem2[i] = 8'h00;
    end
    mem1[0] = 8'h11; mem1[1] = 8'h12; mem1[2] = 8'h13;
    mem2[0] = 8'hA1; mem2[1] = 8'hA2;

    // Reset state
    tick(); tick();
    check("reset_outputs", all_outs(), 32'd0);
    reset = 1'b1;
    tick();
    check("idle_outputs", all_outs(), 32'd0);

    // Basic 3+2 drain: renb on start edge, first byte two edges later, 3 cycles per byte
    mem1_count = 5'd3; mem2_count = 5'd2; out_ready = 1'b1;
    do_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_issue", 32'({m1_renb, m2_renb, m1_addrb}), 32'b1_0_0000);
    run_drain(100, -1);
    set_exp_basic();
    compare_stream("basic");
    check("basic_first_valid", 32'(first_valid), 32'd2);
    check("basic_done_at", 32'(done_at), 32'd16);

    // Both counts zero: no bytes, no reads, done on the edge after the start edge
    mem1_count = 5'd0; mem2_count = 5'd0;
    do_start();
    check("empty_not_busy", 32'({busy, out_valid, m1_renb, m2_renb}), 32'd0);
    run_drain(20, -1);
    exp_clear();
    compare_stream("empty");
    check("empty_done_at", 32'(done_at), 32'd1);

    // Full memory 1, memory 2 empty: addresses 0..15, last on the 16th byte
    for (int i = 0; i < 16; i++) mem1[i] = 8'h40 + 8'(i);
    mem1_count = 5'd16; mem2_count = 5'd0;
    do_start();
    run_drain(100, -1);
    exp_clear();
    for (int i = 0; i < 16; i++) begin
      exp_byte(8'h40 + 8'(i), 1'b0, i == 15);
      exp_a1.push_back(4'(i));
    end
    compare_stream("full_m1");

    // Count above 16 clamps to 16, then one byte from memory 2
    mem1_count = 5'd31; mem2_count = 5'd1;
    do_start();
    run_drain(120, -1);
    exp_clear();
    for (int i = 0; i < 16; i++) begin
      exp_byte(8'h40 + 8'(i), 1'b0, 1'b0);
      exp_a1.push_back(4'(i));
    end
    exp_byte(8'hA1, 1'b1, 1'b1);
    exp_a2.push_back(4'd0);
    compare_stream("clamp");

    // Memory 1 empty: drain starts directly on memory 2
    mem1_count = 5'd0; mem2_count = 5'd2;
    do_start();
    run_drain(50, -1);
    exp_clear();
    exp_byte(8'hA1, 1'b1, 1'b0); exp_byte(8'hA2, 1'b1, 1'b1);
    exp_a2.push_back(4'd0); exp_a2.push_back(4'd1);
    compare_stream("m2_only");

    // Backpressure: first byte held 5 cycles with no new read issued
    mem1[0] = 8'h11; mem1[1] = 8'h12; mem1[2] = 8'h13;
    mem1_count = 5'd2; mem2_count = 5'd1; out_ready = 1'b0;
    do_start();
    tick(); tick();
    check("bp_first_valid", 32'({out_valid, out_data}), 32'h111);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold%0d", k),
            32'({out_valid, out_src, out_last, m1_renb, m2_renb, out_data}), 32'h1011);
    end
    out_ready = 1'b1;
    run_drain(50, -1);
    exp_clear();
    exp_byte(8'h11, 1'b0, 1'b0); exp_byte(8'h12, 1'b0, 1'b0); exp_byte(8'hA1, 1'b1, 1'b1);
    exp_a1.push_back(4'd1); exp_a2.push_back(4'd0);
    compare_stream("backpressure");

    // Start re-pulsed mid-drain is ignored: identical stream and timing
    mem1_count = 5'd3; mem2_count = 5'd2;
    do_start();
    run_drain(100, 7);
    set_exp_basic();
    compare_stream("restart_ignored");
    check("restart_done_at", 32'(done_at), 32'd16);

    // Reset during the WAIT of the 2nd byte clears everything; no done pulse
    do_start();
    tick(); tick(); tick(); tick();
    check("pre_reset_wait", 32'({m1_renb, out_valid, busy, m1_addrb}), 32'b0_0_1_0001);
    reset = 1'b0;
    #1;
    check("mid_reset_async", all_outs(), 32'd0);
    tick();
    check("mid_reset_next", all_outs(), 32'd0);
    reset = 1'b1;
    tick();
    check("post_reset_idle", all_outs(), 32'd0);
    do_start();
    run_drain(100, -1);
    set_exp_basic();
    compare_stream("after_reset");
    check("after_reset_done_at", 32'(done_at), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
